// File: rtl/m3_runsequencer.sv
// Run sequencer for the 3-phase motor path: converts operator request edges into
// a ramped speed level, power level, direction and working enable, paced by a 100 Hz tick.
module m3_runsequencer #(
    parameter int SPEED_W    = 8,
    parameter int SPEED_MAX  = 200,
    parameter int SPEED_MIN  = 10,
    parameter int POWER_W    = 4,
    parameter int POWER_MAX  = 15,
    parameter int RAMP_TICKS = 5,
    parameter int REV_DWELL  = 50
) (
    input  logic               clkI,
    input  logic               nRstI,
    input  logic               clk100hzI,
    input  logic               m3startI,
    input  logic               m3forceStopI,
    input  logic               m3invRotateI,
    input  logic               m3speedINCi,
    input  logic               m3speedDECi,
    input  logic               m3powerINCi,
    input  logic               m3powerDECi,
    output logic               workingO,
    output logic               dirO,
    output logic [SPEED_W-1:0] speedLvlO,
    output logic [POWER_W-1:0] powerLvlO,
    output logic [2:0]         stateO,
    output logic               busyO
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_REV_DWELL = 3'd4,
        ST_STOPPING  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] target_q, target_d;
    logic [POWER_W-1:0] power_q, power_d;
    logic               dir_q, dir_d;
    logic               rev_q, rev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         req_q, req_d;
    logic [6:0]         prev_q, prev_d;

    logic [6:0]       rise;
    logic             tick, start_e, rev_e, sinc_e, sdec_e, pinc_e, pdec_e;
    logic [CNT_W-1:0] limit;
    logic             period_done;

    // Bit order: 0 tick source, 1 start, 2 reverse, 3/4 speed inc/dec, 5/6 power inc/dec
    assign req_d  = {m3powerDECi, m3powerINCi, m3speedDECi, m3speedINCi,
                     m3invRotateI, m3startI, clk100hzI};
    assign prev_d = req_q;
    assign rise   = req_q & ~prev_q;
    assign tick    = rise[0];
    assign start_e = rise[1];
    assign rev_e   = rise[2];
    assign sinc_e  = rise[3];
    assign sdec_e  = rise[4];
    assign pinc_e  = rise[5];
    assign pdec_e  = rise[6];

    assign limit = (state_q == ST_REV_DWELL) ? CNT_W'(REV_DWELL - 1) : CNT_W'(RAMP_TICKS - 1);
    assign period_done = tick && (cnt_q == limit);

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        target_d = target_q;
        power_d  = power_q;
        dir_d    = dir_q;
        rev_d    = rev_q;
        cnt_d    = '0;

        if (state_q != ST_STOPPING) begin
            if (sinc_e && !sdec_e && target_q < SPEED_W'(SPEED_MAX))
                target_d = target_q + 1'b1;
            else if (sdec_e && !sinc_e && target_q > SPEED_W'(SPEED_MIN))
                target_d = target_q - 1'b1;
        end

        if (pinc_e && !pdec_e && power_q < POWER_W'(POWER_MAX))
            power_d = power_q + 1'b1;
        else if (pdec_e && !pinc_e && power_q != '0)
            power_d = power_q - 1'b1;

        if (state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN || state_q == ST_REV_DWELL)
            cnt_d = period_done ? '0 : (tick ? cnt_q + 1'b1 : cnt_q);

        case (state_q)
            ST_IDLE: begin
                if (start_e && !m3forceStopI) begin
                    state_d = ST_RAMP_UP;
                    speed_d = SPEED_W'(SPEED_MIN);
                end
            end
            ST_RAMP_UP: begin
                if (rev_e) begin
                    rev_d   = 1'b1;
                    state_d = ST_RAMP_DOWN;
                end else if (speed_q == target_q) begin
                    state_d = ST_RUN;
                end else if (target_q < speed_q) begin
                    state_d = ST_RAMP_DOWN;
                end else if (period_done) begin
                    speed_d = speed_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (rev_e) begin
                    rev_d   = 1'b1;
                    state_d = ST_RAMP_DOWN;
                end else if (target_q > speed_q) begin
                    state_d = ST_RAMP_UP;
                end else if (target_q < speed_q) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                // A pending reversal ignores the target and runs all the way to zero
                if (rev_q) begin
                    if (speed_q == '0)
                        state_d = ST_REV_DWELL;
                    else if (period_done)
                        speed_d = speed_q - 1'b1;
                end else if (rev_e) begin
                    rev_d = 1'b1;
                end else if (speed_q <= target_q) begin
                    state_d = ST_RUN;
                end else if (period_done) begin
                    speed_d = speed_q - 1'b1;
                end
            end
            ST_REV_DWELL: begin
                if (period_done) begin
                    dir_d   = ~dir_q;
                    rev_d   = 1'b0;
                    speed_d = SPEED_W'(SPEED_MIN);
                    state_d = ST_RAMP_UP;
                end
            end
            ST_STOPPING: begin
                if (speed_q == '0) begin
                    state_d = ST_IDLE;
                    power_d = '0;
                end else if (tick) begin
                    speed_d = speed_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (m3forceStopI && state_q != ST_IDLE && state_q != ST_STOPPING) begin
            state_d = ST_STOPPING;
            speed_d = speed_q;
            dir_d   = dir_q;
            rev_d   = 1'b0;
        end

        if (state_d != state_q)
            cnt_d = '0;
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state_q  <= ST_IDLE;
            speed_q  <= '0;
            target_q <= SPEED_W'(SPEED_MIN);
            power_q  <= '0;
            dir_q    <= 1'b0;
            rev_q    <= 1'b0;
            cnt_q    <= '0;
            req_q    <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            target_q <= target_d;
            power_q  <= power_d;
            dir_q    <= dir_d;
            rev_q    <= rev_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            prev_q   <= prev_d;
        end
    end

    assign workingO  = (state_q != ST_IDLE);
    assign dirO      = dir_q;
    assign speedLvlO = speed_q;
    assign powerLvlO = power_q;
    assign stateO    = state_q;
    assign busyO     = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN) ||
                       (state_q == ST_REV_DWELL) || (state_q == ST_STOPPING);

endmodule

// File: tb/tb_m3_runsequencer.sv
// Directed bench for m3_runsequencer: a table of operations with hand-computed expected
// outputs, plus hand-written sequences for force stop timing and asynchronous reset.
module tb_m3_runsequencer;

    localparam int OP_PINC  = 0;
    localparam int OP_PDEC  = 1;
    localparam int OP_SINC  = 2;
    localparam int OP_SDEC  = 3;
    localparam int OP_BOTH  = 4;
    localparam int OP_START = 5;
    localparam int OP_REV   = 6;
    localparam int OP_TICK  = 7;
    localparam int OP_FOFF  = 8;

    localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_RUN = 3'd2,
                           S_DOWN = 3'd3, S_DWELL = 3'd4, S_STOP = 3'd5;

    typedef struct {
        int         op;
        int         n;
        logic [2:0] st;
        logic [7:0] spd;
        logic [3:0] pwr;
        logic       dir;
        logic       work;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk100 = 1'b0, start = 1'b0, fstop = 1'b0, inv = 1'b0;
    logic       sinc = 1'b0, sdec = 1'b0, pinc = 1'b0, pdec = 1'b0;
    logic       working, dir, busy;
    logic [7:0] speed;
    logic [3:0] power;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    vec_t vecs[36];

    m3_runsequencer dut (
        .clkI(clk), .nRstI(rst_n), .clk100hzI(clk100), .m3startI(start),
        .m3forceStopI(fstop), .m3invRotateI(inv), .m3speedINCi(sinc),
        .m3speedDECi(sdec), .m3powerINCi(pinc), .m3powerDECi(pdec),
        .workingO(working), .dirO(dir), .speedLvlO(speed), .powerLvlO(power),
        .stateO(state), .busyO(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d dir=%0d work=%0d busy=%0d spd=%0d pwr=%0d, want st=%0d dir=%0d work=%0d busy=%0d spd=%0d pwr=%0d",
                     name, act[18:16], act[15], act[14], act[13], act[12:5], act[4:0],
                     exp[18:16], exp[15], exp[14], exp[13], exp[12:5], exp[4:0]);
        end
    endtask

    function automatic logic [18:0] pack(input logic [2:0] st, input logic d, input logic w,
                                         input logic [7:0] s, input logic [3:0] p);
        logic b;
        b = (st == S_UP) || (st == S_DOWN) || (st == S_DWELL) || (st == S_STOP);
        return {st, d, w, b, s, 1'b0, p};
    endfunction

    function automatic logic [18:0] actual();
        return {state, dir, working, busy, speed, 1'b0, power};
    endfunction

    task automatic pulse(input int op, input int n);
        for (int i = 0; i < n; i++) begin
            case (op)
                OP_PINC:  pinc = 1'b1;
                OP_PDEC:  pdec = 1'b1;
                OP_SINC:  sinc = 1'b1;
                OP_SDEC:  sdec = 1'b1;
                OP_BOTH:  begin sinc = 1'b1; sdec = 1'b1; end
                OP_START: start = 1'b1;
                OP_REV:   inv = 1'b1;
                default:  ;
            endcase
            repeat (2) @(negedge clk);
            {pinc, pdec, sinc, sdec, start, inv} = '0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clk100 = 1'b1;
            @(negedge clk);
            clk100 = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            case (vecs[i].op)
                OP_TICK: ticks(vecs[i].n);
                OP_FOFF: begin fstop = 1'b0; repeat (2) @(negedge clk); end
                default: pulse(vecs[i].op, vecs[i].n);
            endcase
            check($sformatf("row%0d", i), actual(),
                  pack(vecs[i].st, vecs[i].dir, vecs[i].work, vecs[i].spd, vecs[i].pwr));
        end
    endtask

    initial begin
        vecs[0]  = '{OP_PINC, 20, S_IDLE, 0, 15, 0, 0};
        vecs[1]  = '{OP_PDEC, 20, S_IDLE, 0, 0, 0, 0};
        vecs[2]  = '{OP_PINC, 7, S_IDLE, 0, 7, 0, 0};
        vecs[3]  = '{OP_START, 1, S_RUN, 10, 7, 0, 1};
        vecs[4]  = '{OP_SINC, 10, S_UP, 10, 7, 0, 1};
        vecs[5]  = '{OP_TICK, 49, S_UP, 19, 7, 0, 1};
        vecs[6]  = '{OP_TICK, 1, S_RUN, 20, 7, 0, 1};
        vecs[7]  = '{OP_BOTH, 1, S_RUN, 20, 7, 0, 1};
        vecs[8]  = '{OP_SINC, 10, S_UP, 20, 7, 0, 1};
        vecs[9]  = '{OP_TICK, 50, S_RUN, 30, 7, 0, 1};
        vecs[10] = '{OP_TICK, 29, S_STOP, 1, 7, 0, 1};
        vecs[11] = '{OP_TICK, 1, S_IDLE, 0, 0, 0, 0};
        vecs[12] = '{OP_START, 1, S_IDLE, 0, 0, 0, 0};
        vecs[13] = '{OP_FOFF, 0, S_IDLE, 0, 0, 0, 0};
        vecs[14] = '{OP_SDEC, 20, S_IDLE, 0, 0, 0, 0};
        vecs[15] = '{OP_START, 1, S_RUN, 10, 0, 0, 1};
        vecs[16] = '{OP_SINC, 10, S_UP, 10, 0, 0, 1};
        vecs[17] = '{OP_TICK, 50, S_RUN, 20, 0, 0, 1};
        vecs[18] = '{OP_REV, 1, S_DOWN, 20, 0, 0, 1};
        vecs[19] = '{OP_TICK, 99, S_DOWN, 1, 0, 0, 1};
        vecs[20] = '{OP_TICK, 1, S_DWELL, 0, 0, 0, 1};
        vecs[21] = '{OP_TICK, 25, S_DWELL, 0, 0, 0, 1};
        vecs[22] = '{OP_REV, 1, S_DWELL, 0, 0, 0, 1};
        vecs[23] = '{OP_TICK, 24, S_DWELL, 0, 0, 0, 1};
        vecs[24] = '{OP_TICK, 1, S_UP, 10, 0, 1, 1};
        vecs[25] = '{OP_TICK, 50, S_RUN, 20, 0, 1, 1};
        vecs[26] = '{OP_SINC, 250, S_UP, 20, 0, 1, 1};
        vecs[27] = '{OP_TICK, 900, S_RUN, 200, 0, 1, 1};
        vecs[28] = '{OP_TICK, 10, S_RUN, 200, 0, 1, 1};
        vecs[29] = '{OP_SDEC, 250, S_DOWN, 200, 0, 1, 1};
        vecs[30] = '{OP_TICK, 950, S_RUN, 10, 0, 1, 1};
        vecs[31] = '{OP_PINC, 3, S_RUN, 10, 3, 1, 1};
        vecs[32] = '{OP_SINC, 10, S_UP, 10, 3, 1, 1};
        vecs[33] = '{OP_TICK, 50, S_RUN, 20, 3, 1, 1};
        vecs[34] = '{OP_REV, 1, S_DOWN, 20, 3, 1, 1};
        vecs[35] = '{OP_TICK, 20, S_DOWN, 16, 3, 1, 1};

        // Clock/reset
        repeat (3) @(negedge clk);
        check("reset_held", actual(), pack(S_IDLE, 0, 0, 0, 0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_released", actual(), pack(S_IDLE, 0, 0, 0, 0));

        run_rows(0, 9);

        // Force stop takes effect on the very next clock edge
        fstop = 1'b1;
        @(negedge clk);
        check("fstop_next_cycle", actual(), pack(S_STOP, 0, 1, 30, 7));
        pulse(OP_START, 1);
        check("fstop_start_ignored", actual(), pack(S_STOP, 0, 1, 30, 7));

        run_rows(10, 35);

        // Asynchronous reset in the middle of a reversing ramp-down
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid", actual(), pack(S_IDLE, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(OP_START, 1);
        check("restart_forward", actual(), pack(S_RUN, 0, 1, 10, 0));
        ticks(60);
        check("restart_stays_forward", actual(), pack(S_RUN, 0, 1, 10, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
